r16_n_loader: RTL and testbench
===============================

R16_N_LOADER -- requirements
Module: r16_n_loader

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 64, giving the width of modulus N.
REQ-002 The block SHALL have parameter P_WORD, default 16, giving the input word width; P_WIDTH SHALL be an integer multiple of P_WORD.
REQ-003 The block SHALL have parameter P_ZERO, default 64'h0, giving the reset value of N_out.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-006 The block SHALL have port word_in, input, P_WORD bits, the modulus word, least-significant word first.
REQ-007 The block SHALL have port word_valid, input, 1 bit, meaning word_in is valid.
REQ-008 The block SHALL have port word_ready, output, 1 bit, meaning the block can accept a word this cycle.
REQ-009 The block SHALL have port abort, input, 1 bit, which discards a partially collected modulus.
REQ-010 The block SHALL have port N_hold, input, 1 bit, which makes the downstream pipeline forbid an N_out change this cycle.
REQ-011 The block SHALL have port N_out, output, P_WIDTH bits, the committed modulus, registered, which feeds the N pipe registers.
REQ-012 The block SHALL have port N_update, output, 1 bit, a one-cycle pulse in the cycle after N_out changes.
REQ-013 The block SHALL have port N_valid, output, 1 bit, held high once any modulus has been committed since reset.
REQ-014 The block SHALL have port busy, output, 1 bit, high in S_COLLECT or S_PENDING.

Function
REQ-015 A word SHALL be accepted on a rising edge where word_valid=1, word_ready=1 and abort=0.
REQ-016 Accepted word k (k=0..NW-1, NW=P_WIDTH/P_WORD) SHALL be written to shadow bits [k*P_WORD +: P_WORD].
REQ-017 The FSM states SHALL be S_IDLE, S_COLLECT and S_PENDING.
REQ-018 In S_IDLE, accepting word 0 SHALL move the FSM to S_COLLECT with word counter cnt=1.
REQ-019 In S_COLLECT, each accepted word SHALL increment cnt.
REQ-020 When word NW-1 is accepted and N_hold=0 on that edge, shadow plus that word SHALL be committed to N_out on the same edge and the FSM SHALL go to S_IDLE with cnt=0.
REQ-021 When word NW-1 is accepted and N_hold=1, the FSM SHALL go to S_PENDING.
REQ-022 In S_PENDING, the block SHALL commit on the first edge with N_hold=0 and then go to S_IDLE.
REQ-023 word_ready SHALL be 1 in S_IDLE and S_COLLECT and 0 in S_PENDING; it SHALL be combinational from state only, with no dependence on word_valid.
REQ-024 abort=1 on an edge SHALL force S_IDLE and cnt=0, with no commit and N_out unchanged; abort SHALL win over a simultaneous word acceptance and over a pending commit.
REQ-025 N_out SHALL change only on a commit edge, and SHALL change atomically (all P_WIDTH bits together); partial words SHALL never appear on N_out.
REQ-026 N_update SHALL be 1 for exactly the cycle following each commit edge and 0 otherwise.
REQ-027 N_valid SHALL be set on the first commit and cleared only by reset.
REQ-028 cnt SHALL be $clog2(NW) bits wide and SHALL wrap to 0 on commit; it SHALL never exceed NW-1 while in S_COLLECT.
REQ-029 Word acceptance latency SHALL be 0 cycles (same edge), and commit latency after the last word SHALL be 0 cycles when N_hold=0.

Reset
REQ-030 While rst_n=0, asynchronously: state=S_IDLE, cnt=0, shadow=0, N_out=P_ZERO, N_update=0, N_valid=0, busy=0, word_ready=1.
REQ-031 A reset asserted mid-collection or in S_PENDING SHALL discard all partial data, with no commit.

Structure
REQ-032 A shared package r16_pkg SHALL hold P_WIDTH, P_WORD, NW, the zero constant and the state encoding (S_IDLE=2'd0, S_COLLECT=2'd1, S_PENDING=2'd2).
REQ-033 The block SHALL be a single flat module; no sub-module is natural, since the shadow register, counter and FSM are tightly coupled.

Verification
REQ-034 Words 16'h0001, 16'h0002, 16'h0003, 16'h0004 on four consecutive cycles with N_hold=0 -> N_out=64'h0004_0003_0002_0001 on the 4th edge, N_update=1 for one cycle, N_valid=1.
REQ-035 Same four words with N_hold=1 for 3 cycles after the last word -> word_ready=0, N_out unchanged for 3 cycles, commit on the first edge with N_hold=0, N_update pulses once.
REQ-036 Two words accepted, then abort=1 together with word_valid=1 -> FSM in S_IDLE, cnt=0, N_out unchanged; the next four words 16'hAAAA x4 -> N_out=64'hAAAA_AAAA_AAAA_AAAA.
REQ-037 rst_n dropped asynchronously mid-cycle in S_PENDING -> N_out=0, N_valid=0, busy=0 immediately, with no commit after rst_n rises.
REQ-038 Word_valid gapped (one word every 3 cycles) -> identical result to the back-to-back case; busy stays high from the first word until the commit.
REQ-039 Two back-to-back moduli (8 words, no gaps, N_hold=0) -> two N_update pulses 4 cycles apart, with N_out equal to the second modulus at the end.

Source files
------------

// File: rtl/r16_pkg.sv
// Shared constants and state encoding for the 16-bit-word modulus loader.
package r16_pkg;

    localparam int P_WIDTH = 64;
    localparam int P_WORD  = 16;
    localparam int NW      = P_WIDTH / P_WORD;
    localparam logic [P_WIDTH-1:0] N_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/r16_n_loader.sv
// Collects a modulus word by word into a shadow register and commits it to N_out
// atomically, deferring the commit while the downstream pipe holds N steady.
module r16_n_loader
    import r16_pkg::state_t, r16_pkg::S_IDLE, r16_pkg::S_COLLECT, r16_pkg::S_PENDING;
#(
    parameter int P_WIDTH = r16_pkg::P_WIDTH,
    parameter int P_WORD  = r16_pkg::P_WORD,
    parameter logic [P_WIDTH-1:0] P_ZERO = r16_pkg::N_ZERO,
    localparam int NW = P_WIDTH / P_WORD,
    localparam int CW = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WORD-1:0]  word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic               abort,
    input  logic               N_hold,
    output logic [P_WIDTH-1:0] N_out,
    output logic               N_update,
    output logic               N_valid,
    output logic               busy,
    output state_t             dbg_state,
    output logic [CW-1:0]      dbg_cnt
);

    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    // Handshake: a word moves on a rising edge with word_valid && word_ready && !abort;
    // word_ready depends on state only, never on word_valid.
    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [P_WIDTH-1:0]  shadow, shadow_nxt;
    logic                accept, last_word, commit;

    assign accept    = word_valid && word_ready && !abort;
    assign last_word = accept && (cnt == LAST);
    // Direct commit on the last word, or deferred commit out of S_PENDING.
    assign commit    = !abort && !N_hold && (last_word || (state == S_PENDING));

    always_comb begin
        shadow_nxt = shadow;
        if (accept) begin
            shadow_nxt[int'(cnt)*P_WORD +: P_WORD] = word_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (accept) begin
                    if (last_word) begin
                        state_nxt = N_hold ? S_PENDING : S_IDLE;
                    end else begin
                        state_nxt = S_COLLECT;
                    end
                end
            end
            S_PENDING: begin
                if (!N_hold) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        word_ready = (state != S_PENDING);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            shadow   <= '0;
            N_out    <= P_ZERO;
            N_update <= 1'b0;
            N_valid  <= 1'b0;
        end else begin
            shadow   <= shadow_nxt;
            N_update <= commit;
            if (abort) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= last_word ? '0 : cnt + 1'b1;
            end
            if (commit) begin
                N_out   <= shadow_nxt;
                N_valid <= 1'b1;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_r16_n_loader.sv
// Directed bench for r16_n_loader: hand-computed moduli, hold, abort and reset cases.
module tb_r16_n_loader;
    import r16_pkg::state_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        abort;
    logic        N_hold;
    logic [63:0] N_out;
    logic        N_update;
    logic        N_valid;
    logic        busy;
    state_t      dbg_state;
    logic [1:0]  dbg_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    r16_n_loader dut (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .abort(abort), .N_hold(N_hold), .N_out(N_out),
        .N_update(N_update), .N_valid(N_valid), .busy(busy),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every N_update pulse must carry the next expected modulus.
    always @(negedge clk) begin
        if (rst_n && N_update) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_update", 64'd1, 64'd0);
            end else begin
                check("sb_n_out", N_out, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input logic hold);
        word_in    = w;
        word_valid = 1'b1;
        N_hold     = hold;
        step();
        word_valid = 1'b0;
    endtask

    logic [63:0] m;
    logic [63:0] prev;

    initial begin
        rst_n = 1'b0; word_in = '0; word_valid = 1'b0; abort = 1'b0; N_hold = 1'b0;
        repeat (2) step();
        check("rst_n_out", N_out, 64'h0);
        check("rst_n_valid", {63'd0, N_valid}, 64'd0);
        check("rst_n_update", {63'd0, N_update}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, word_ready}, 64'd1);
        check("rst_state", {62'd0, dbg_state}, 64'd0);
        check("rst_cnt", {62'd0, dbg_cnt}, 64'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back load
        m = 64'h0004_0003_0002_0001;
        exp_q.push_back(m);
        send_word(16'h0001, 1'b0);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        check("b2b_cnt1", {62'd0, dbg_cnt}, 64'd1);
        check("b2b_no_partial", N_out, 64'h0);
        send_word(16'h0002, 1'b0);
        send_word(16'h0003, 1'b0);
        send_word(16'h0004, 1'b0);
        check("b2b_n_out", N_out, m);
        check("b2b_update", {63'd0, N_update}, 64'd1);
        check("b2b_valid", {63'd0, N_valid}, 64'd1);
        check("b2b_idle", {62'd0, dbg_state}, 64'd0);
        step();
        check("b2b_update_low", {63'd0, N_update}, 64'd0);

        // Hold delays the commit
        prev = m;
        m = 64'h4444_3333_2222_1111;
        exp_q.push_back(m);
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b1);
        check("hold_state", {62'd0, dbg_state}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            check("hold_ready", {63'd0, word_ready}, 64'd0);
            check("hold_n_out", N_out, prev);
            check("hold_update", {63'd0, N_update}, 64'd0);
            check("hold_busy", {63'd0, busy}, 64'd1);
            step();
        end
        N_hold = 1'b0;
        step();
        check("hold_commit", N_out, m);
        check("hold_update_pulse", {63'd0, N_update}, 64'd1);
        check("hold_idle", {62'd0, dbg_state}, 64'd0);
        step();
        check("hold_update_low", {63'd0, N_update}, 64'd0);

        // Abort wins over a simultaneous word
        prev = m;
        send_word(16'h5555, 1'b0);
        send_word(16'h6666, 1'b0);
        abort = 1'b1;
        send_word(16'h7777, 1'b0);
        abort = 1'b0;
        check("abort_state", {62'd0, dbg_state}, 64'd0);
        check("abort_cnt", {62'd0, dbg_cnt}, 64'd0);
        check("abort_n_out", N_out, prev);
        check("abort_update", {63'd0, N_update}, 64'd0);
        m = 64'hAAAA_AAAA_AAAA_AAAA;
        exp_q.push_back(m);
        for (int i = 0; i < 4; i++) send_word(16'hAAAA, 1'b0);
        check("abort_reload", N_out, m);
        step();

        // Asynchronous reset while pending
        send_word(16'h9999, 1'b0);
        send_word(16'h8888, 1'b0);
        send_word(16'h7777, 1'b0);
        send_word(16'h6666, 1'b1);
        check("rstp_state", {62'd0, dbg_state}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rstp_n_out", N_out, 64'h0);
        check("rstp_valid", {63'd0, N_valid}, 64'd0);
        check("rstp_busy", {63'd0, busy}, 64'd0);
        check("rstp_ready", {63'd0, word_ready}, 64'd1);
        step();
        N_hold = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstp_no_commit", N_out, 64'h0);
            check("rstp_no_update", {63'd0, N_update}, 64'd0);
            check("rstp_no_valid", {63'd0, N_valid}, 64'd0);
        end

        // Gapped words: same result, busy held through the gaps
        m = 64'h0004_0003_0002_0001;
        exp_q.push_back(m);
        for (int k = 0; k < 4; k++) begin
            send_word(16'(k + 1), 1'b0);
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    check("gap_busy", {63'd0, busy}, 64'd1);
                    check("gap_n_out", N_out, 64'h0);
                    step();
                end
            end
        end
        check("gap_n_out_final", N_out, m);
        check("gap_update", {63'd0, N_update}, 64'd1);
        check("gap_busy_low", {63'd0, busy}, 64'd0);
        check("gap_valid", {63'd0, N_valid}, 64'd1);

        // Two moduli back-to-back: pulses exactly 4 cycles apart
        exp_q.push_back(64'h0D0D_0C0C_0B0B_0A0A);
        exp_q.push_back(64'hF00D_BEEF_CAFE_1234);
        begin
            logic [15:0] words [8];
            words = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D,
                      16'h1234, 16'hCAFE, 16'hBEEF, 16'hF00D};
            for (int k = 0; k < 8; k++) begin
                word_in = words[k]; word_valid = 1'b1; N_hold = 1'b0;
                step();
                check("two_update", {63'd0, N_update}, (k == 3 || k == 7) ? 64'd1 : 64'd0);
            end
            word_valid = 1'b0;
        end
        check("two_final", N_out, 64'hF00D_BEEF_CAFE_1234);
        step();
        check("two_update_low", {63'd0, N_update}, 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
